multi_cycle_core: RTL and testbench

Multi-cycle RV32I-subset processor core that replaces the single-cycle top. One FSM-controlled datapath shares a single ALU and one unified instruction/data memory port, using a req/ready handshake that tolerates any number of wait states. Reset PC and register-file depth (RV32I/RV32E) are parameters. It adds trap and halt detection plus a retire strobe for the bench. Register file, ALU, sign-extend and decoder stay internal to this block.

---
 rtl/multi_cycle_core.sv | 269 ++++++++++++++++++++++++++
 tb/tb_multi_cycle_core.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_core.sv
// multi_cycle_core: multi-cycle RV32I-subset core (add, sub, and, or, slt,
// addi, lw, sw, beq, jal). A single FSM steps one shared ALU and one unified
// instruction/data memory port. Illegal encodings, out-of-range register
// indices, misaligned data addresses and misaligned jump/branch targets
// park the core in TRAP (halt=1) until reset.
//
// Memory handshake: mem_req is a Moore output of the state. While
// mem_req=1, the signals mem_we, mem_addr and mem_wdata hold steady. The
// transfer completes on the first rising edge that sees mem_req && mem_ready.
// Read data is sampled on that edge. Any number of wait cycles is allowed.
module multi_cycle_core #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          REG_COUNT = 32   // 32 (RV32I) or 16 (RV32E) only
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire,
    output logic [31:0] pc_out,
    output logic        halt
);

    localparam int         IDX_W     = (REG_COUNT == 16) ? 4 : 5;
    localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    state_t      state, state_next;
    logic [31:0] pc, old_pc, ir, a_reg, b_reg, alu_out, mdr, br_target;
    logic [31:0] regs [REG_COUNT];

    // Instruction fields and immediates
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    logic    is_r, is_addi, is_lw, is_sw, is_beq, is_jal, legal;
    alu_op_t r_op;

    // Decode the instruction class; anything unrecognised leaves legal=0
    always_comb begin
        is_r    = 1'b0;
        is_addi = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_beq  = 1'b0;
        is_jal  = 1'b0;
        r_op    = ALU_ADD;
        case (opcode)
            7'b0110011: begin
                case ({funct7, funct3})
                    10'b0000000_000: begin is_r = 1'b1; r_op = ALU_ADD; end
                    10'b0100000_000: begin is_r = 1'b1; r_op = ALU_SUB; end
                    10'b0000000_111: begin is_r = 1'b1; r_op = ALU_AND; end
                    10'b0000000_110: begin is_r = 1'b1; r_op = ALU_OR;  end
                    10'b0000000_010: begin is_r = 1'b1; r_op = ALU_SLT; end
                    default:         is_r = 1'b0;
                endcase
            end
            7'b0010011: is_addi = (funct3 == 3'b000);
            7'b0000011: is_lw   = (funct3 == 3'b010);
            7'b0100011: is_sw   = (funct3 == 3'b010);
            7'b1100011: is_beq  = (funct3 == 3'b000);
            7'b1101111: is_jal  = 1'b1;
            default:    is_r    = 1'b0;
        endcase
    end

    assign legal = is_r | is_addi | is_lw | is_sw | is_beq | is_jal;

    // Only the register fields an instruction actually uses are range-checked
    logic uses_rs1, uses_rs2, uses_rd, idx_bad;
    assign uses_rs1 = is_r | is_addi | is_lw | is_sw | is_beq;
    assign uses_rs2 = is_r | is_sw | is_beq;
    assign uses_rd  = is_r | is_addi | is_lw | is_jal;
    assign idx_bad  = (uses_rs1 && ({1'b0, rs1} >= REG_LIMIT)) ||
                      (uses_rs2 && ({1'b0, rs2} >= REG_LIMIT)) ||
                      (uses_rd  && ({1'b0, rd}  >= REG_LIMIT));

    // Register-file read ports; x0 is never written so it always reads 0
    logic [31:0] rf_a, rf_b, rf_wdata;
    logic        rf_we;
    assign rf_a     = regs[rs1[IDX_W-1:0]];
    assign rf_b     = regs[rs2[IDX_W-1:0]];
    assign rf_we    = ((state == S_ALUWB) || (state == S_MEMWB)) && (rd != 5'd0);
    assign rf_wdata = (state == S_MEMWB) ? mdr : alu_out;

    // Shared ALU: operand selection depends on the current state
    logic [31:0] alu_a, alu_b, alu_y;
    alu_op_t     alu_op;
    always_comb begin
        alu_a  = a_reg;
        alu_b  = b_reg;
        alu_op = ALU_ADD;
        case (state)
            S_FETCH:  begin alu_a = pc;     alu_b = 32'd4; end
            S_DECODE: begin alu_a = old_pc; alu_b = imm_b; end
            S_MEMADR: alu_b = is_sw ? imm_s : imm_i;
            S_EXEC_R: alu_op = r_op;
            S_EXEC_I: alu_b = imm_i;
            S_BEQ:    alu_op = ALU_SUB;
            S_JAL:    begin alu_a = old_pc; alu_b = imm_j; end
            default:  alu_op = ALU_ADD;
        endcase
    end

    // ALU function, 32-bit wrap-around; slt is a signed compare
    always_comb begin
        case (alu_op)
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    logic beq_take;
    assign beq_take = (alu_y == 32'd0);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next state and Moore memory outputs; retire marks the last cycle of an instruction
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        retire     = 1'b0;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (!legal || idx_bad)   state_next = S_TRAP;
                else if (is_lw || is_sw) state_next = S_MEMADR;
                else if (is_r)           state_next = S_EXEC_R;
                else if (is_addi)        state_next = S_EXEC_I;
                else if (is_beq)         state_next = S_BEQ;
                else                     state_next = S_JAL;
            end
            S_MEMADR: begin
                if (alu_y[1:0] != 2'b00) state_next = S_TRAP;
                else if (is_lw)          state_next = S_MEMREAD;
                else                     state_next = S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req  = 1'b1;
                mem_addr = alu_out;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = alu_out;
                mem_wdata = b_reg;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXEC_R, S_EXEC_I: state_next = S_ALUWB;
            S_ALUWB: begin
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                if (beq_take && (br_target[1:0] != 2'b00)) begin
                    state_next = S_TRAP;
                end else begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_JAL: begin
                if (alu_y[1:0] != 2'b00) state_next = S_TRAP;
                else                     state_next = S_ALUWB;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_TRAP;
        endcase
    end

    // Datapath registers loaded according to the state being left
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= RESET_PC;
            old_pc    <= 32'd0;
            ir        <= 32'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            alu_out   <= 32'd0;
            mdr       <= 32'd0;
            br_target <= 32'd0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir     <= mem_rdata;
                    old_pc <= pc;
                    pc     <= alu_y;
                end
                S_DECODE: begin
                    a_reg     <= rf_a;
                    b_reg     <= rf_b;
                    br_target <= alu_y;
                end
                S_MEMADR, S_EXEC_R, S_EXEC_I: alu_out <= alu_y;
                S_MEMREAD: if (mem_ready) mdr <= mem_rdata;
                S_BEQ: if (beq_take && (br_target[1:0] == 2'b00)) pc <= br_target;
                // pc already holds old_pc+4 here, which is the link value
                S_JAL: if (alu_y[1:0] == 2'b00) begin
                    pc      <= alu_y;
                    alu_out <= pc;
                end
                default: pc <= pc;
            endcase
        end
    end

    // Register file; cleared on reset, written in ALUWB/MEMWB
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= 32'd0;
        end else if (rf_we) begin
            regs[rd[IDX_W-1:0]] <= rf_wdata;
        end
    end

    assign pc_out = pc;
    assign halt   = (state == S_TRAP);

endmodule

// File: tb/tb_multi_cycle_core.sv
// tb_multi_cycle_core: directed bench for multi_cycle_core with a word
// memory model that inserts a programmable number of wait cycles.
module tb_multi_cycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ready, retire, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

  logic [31:0] mem [256];
  int          wait_n = 0;
  int          wcnt;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          ret_q[$];
  logic [31:0] fetch_q[$];
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[11];

  multi_cycle_core #(.RESET_PC(32'h0000_0100), .REG_COUNT(16)) u_dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .pc_out(pc_out), .halt(halt)
  );

  // clock and memory model
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready = mem_req && (wcnt >= wait_n);

  always @(posedge clk or negedge rst) begin
    if (!rst) wcnt <= 0;
    else if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    if (rst && mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] = mem_wdata;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && retire) ret_q.push_back(cyc);
    if (rst && mem_req && mem_ready && !mem_we) fetch_q.push_back(mem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // request signals must not move while a transfer is stalled
  logic        hold_v, hold_we;
  logic [31:0] hold_addr, hold_wdata;
  always @(posedge clk) begin
    hold_v     <= rst && mem_req && !mem_ready;
    hold_addr  <= mem_addr;
    hold_we    <= mem_we;
    hold_wdata <= mem_wdata;
  end
  always @(negedge clk) begin
    if (hold_v && rst) begin
      check("stable_req", 32'(mem_req), 32'd1);
      check("stable_addr", mem_addr, hold_addr);
      check("stable_we", 32'(mem_we), 32'(hold_we));
      check("stable_wdata", mem_wdata, hold_wdata);
    end
  end

  // instruction encoders
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'b000, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] im;
    im = 21'(imm);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
  endfunction
  function automatic logic [31:0] i_addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 7'b0010011);
  endfunction
  function automatic logic [31:0] i_lw(input int rd, input int imm, input int rs1);
    return enc_i(imm, rs1, 2, rd, 7'b0000011);
  endfunction

  // driver tasks
  task automatic put(input logic [31:0] addr, input logic [31:0] data);
    mem[addr[9:2]] = data;
  endtask

  task automatic begin_reset(input int waits);
    rst = 1'b0;
    wait_n = waits;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
    ret_q.delete();
    fetch_q.delete();
    exp_q.delete();
  endtask

  task automatic run_until_halt(input string name, input int budget);
    int n;
    n = 0;
    while (!halt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_halt"}, 32'(halt), 32'd1);
  endtask

  task automatic check_quiet(input string name);
    int reqs;
    reqs = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_req) reqs++;
    end
    check(name, 32'(reqs), 32'd0);
  endtask

  task automatic check_gaps(input string name, input int exp_g[5]);
    check({name, "_retires"}, 32'(ret_q.size()), 32'd6);
    for (int i = 0; i < 5; i++) begin
      if (i + 1 < ret_q.size())
        check($sformatf("%s_gap%0d", name, i), 32'(ret_q[i+1] - ret_q[i]), 32'(exp_g[i]));
    end
  endtask

  task automatic load_main();
    put(32'h100, i_addi(1, 0, 5));
    put(32'h104, i_addi(2, 0, 7));
    put(32'h108, enc_r(0, 2, 1, 0, 3));
    put(32'h10C, enc_s(8, 3, 0));
    put(32'h110, i_lw(4, 8, 0));
    put(32'h114, enc_s(12, 4, 0));
  endtask

  initial begin
    vecs[0]  = '{"add_ovf",  enc_r(7'h00, 2, 1, 0, 3), 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
    vecs[1]  = '{"add_wrap", enc_r(7'h00, 2, 1, 0, 3), 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[2]  = '{"sub_neg",  enc_r(7'h20, 2, 1, 0, 3), 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
    vecs[3]  = '{"and",      enc_r(7'h00, 2, 1, 7, 3), 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
    vecs[4]  = '{"or",       enc_r(7'h00, 2, 1, 6, 3), 32'hF000_000F, 32'h0000_F0F0, 32'hF000_F0FF};
    vecs[5]  = '{"slt_neg",  enc_r(7'h00, 2, 1, 2, 3), 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[6]  = '{"slt_pos",  enc_r(7'h00, 2, 1, 2, 3), 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7]  = '{"slt_eq",   enc_r(7'h00, 2, 1, 2, 3), 32'h0000_0003, 32'h0000_0003, 32'h0000_0000};
    vecs[8]  = '{"addi_m1",  i_addi(3, 1, -1),         32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[9]  = '{"addi_max", i_addi(3, 1, 12'h7FF),    32'h0000_0001, 32'h0000_0000, 32'h0000_0800};
    vecs[10] = '{"add_x0",   enc_r(7'h00, 0, 1, 0, 3), 32'h0000_1234, 32'h5555_5555, 32'h0000_1234};

    // reset values, release timing, then the main program with no wait states
    begin_reset(0);
    load_main();
    check("rst_pc", pc_out, 32'h100);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    rst = 1'b1;
    check("cyc1_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("cyc2_req", 32'(mem_req), 32'd1);
    check("cyc2_addr", mem_addr, 32'h100);
    check("cyc2_we", 32'(mem_we), 32'd0);
    run_until_halt("main0", 300);
    check("main0_word2", mem[2], 32'd12);
    check("main0_x4", mem[3], 32'd12);
    check_gaps("main0", '{4, 4, 4, 5, 4});

    // same program, every access stalled for 3 cycles
    begin_reset(3);
    load_main();
    rst = 1'b1;
    run_until_halt("main3", 600);
    check("main3_word2", mem[2], 32'd12);
    check("main3_x4", mem[3], 32'd12);
    check_gaps("main3", '{7, 7, 10, 11, 10});

    // ALU vectors: load two operands, apply the op, store x3
    for (int v = 0; v < 11; v++) begin
      begin_reset(0);
      put(32'h100, i_lw(1, 32'h40, 0));
      put(32'h104, i_lw(2, 32'h44, 0));
      put(32'h108, vecs[v].instr);
      put(32'h10C, enc_s(32'h48, 3, 0));
      put(32'h40, vecs[v].a);
      put(32'h44, vecs[v].b);
      rst = 1'b1;
      run_until_halt(vecs[v].name, 200);
      check(vecs[v].name, mem[18], vecs[v].exp);
    end

    // branch and jumps: fetch order, link value, beq CPI
    begin_reset(0);
    put(32'h100, i_addi(1, 0, 3));
    put(32'h104, enc_j(-32'sh0F4, 0));
    put(32'h010, enc_b(-8, 1, 1));
    put(32'h008, enc_j(32'h18, 0));
    put(32'h020, enc_j(16, 5));
    put(32'h030, enc_s(32'h48, 5, 0));
    exp_q = '{32'h100, 32'h104, 32'h010, 32'h008, 32'h020, 32'h030, 32'h034};
    rst = 1'b1;
    run_until_halt("br", 300);
    check("br_fetches", 32'(fetch_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < fetch_q.size()) check($sformatf("br_fetch%0d", i), fetch_q[i], exp_q[i]);
    end
    check("br_link_x5", mem[18], 32'h24);
    check("br_pc_final", pc_out, 32'h38);
    check_gaps("br", '{4, 3, 4, 4, 4});

    // lw from a misaligned address traps before touching x4
    begin_reset(0);
    put(32'h100, i_addi(4, 0, 32'h55));
    put(32'h104, i_lw(4, 6, 0));
    put(32'h108, enc_s(32'h50, 4, 0));
    rst = 1'b1;
    run_until_halt("lw_mis", 200);
    check("lw_mis_x4", u_dut.regs[4], 32'h55);
    check("lw_mis_nostore", mem[20], 32'hFFFF_FFFF);
    check("lw_mis_pc", pc_out, 32'h108);
    check_quiet("lw_mis_quiet");

    // rd=x20 does not exist with 16 registers
    begin_reset(0);
    put(32'h100, i_addi(1, 0, 9));
    put(32'h104, enc_s(32'h50, 1, 0));
    put(32'h108, i_addi(20, 0, 1));
    put(32'h10C, enc_s(32'h54, 1, 0));
    rst = 1'b1;
    run_until_halt("rd20", 200);
    check("rd20_before", mem[20], 32'd9);
    check("rd20_after", mem[21], 32'hFFFF_FFFF);
    check("rd20_pc", pc_out, 32'h10C);
    check_quiet("rd20_quiet");

    // jal to a misaligned target traps with pc and rd untouched
    begin_reset(0);
    put(32'h100, i_addi(6, 0, 32'h33));
    put(32'h104, enc_j(6, 6));
    rst = 1'b1;
    run_until_halt("jal_mis", 200);
    check("jal_mis_pc", pc_out, 32'h108);
    check("jal_mis_x6", u_dut.regs[6], 32'h33);
    check_quiet("jal_mis_quiet");

    // reset while a store is stalled: request drops at once, no write lands
    begin_reset(3);
    put(32'h100, i_addi(1, 0, 7));
    put(32'h104, enc_s(32'h50, 1, 0));
    rst = 1'b1;
    begin
      int n;
      n = 0;
      while (!(mem_req && mem_we) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("abort_saw_store", 32'(mem_req && mem_we), 32'd1);
    end
    check("abort_addr", mem_addr, 32'h50);
    rst = 1'b0;
    #1;
    check("abort_req", 32'(mem_req), 32'd0);
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_pc", pc_out, 32'h100);
    @(negedge clk);
    @(negedge clk);
    check("abort_nowrite", mem[20], 32'hFFFF_FFFF);
    wait_n = 0;
    rst = 1'b1;
    run_until_halt("abort_rerun", 200);
    check("abort_rerun_word", mem[20], 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
